// File: rtl/rfsoc_gpio_cfg_bank_pkg.sv
// rfsoc_config: shared definitions for the RFSoC GPIO configuration bank.
//
// Holds the PS GPIO line map used by the PL decoder, the configuration
// register enumeration and the default widths of the GPIO bus and of one
// configuration register.
//
// GPIO line map:
//   sdata      (0)     shared serial data
//   ch_sel_clk (1)     serial clock of the channel-select shift register
//   pl_rst     (2)     soft-reset level
//   trigger    (3)     trigger request
//   4..11              per-register serial clocks, indexed by cfg_reg_e
//   cfg_commit (15)    stage-to-active commit strobe
package rfsoc_config;

    localparam int config_reg_width = 32;
    localparam int gpio_bus_width   = 16;

    localparam int sdata      = 0;
    localparam int ch_sel_clk = 1;
    localparam int pl_rst     = 2;
    localparam int trigger    = 3;
    localparam int cfg_commit = 15;

    typedef enum logic [2:0] {
        MASK,
        CYCLE_COUNT,
        MUX_SET,
        ADC_SHIFT,
        ADC_NUM_CYCLES,
        PRE_DELAY,
        POST_DELAY,
        LOCK_WAVE
    } cfg_reg_e;

    localparam int NUM_CFG_REGS = 8;

    // Serial clock line for each configuration register, in cfg_reg_e order.
    localparam int CFG_CLK_IDX [NUM_CFG_REGS] = '{4, 5, 6, 7, 8, 9, 10, 11};

endpackage

// File: rtl/rfsoc_gpio_cfg_bank_sync_edge.sv
// rfsoc_gpio_sync_edge: multi-flop synchroniser plus rising-edge detector
// for the asynchronous PS GPIO bus.
//
// Ports:
//   clk, rstn   fabric clock, asynchronous active-low reset
//   gpio_raw    raw GPIO bus, asynchronous to clk
//   level       synchronised level (last synchroniser stage)
//   rise        one-cycle pulse on each synchronised rising edge
//
// Level and rise come from the same stage, so a data line sampled through
// level lines up exactly with a clock line seen through rise.
module rfsoc_gpio_sync_edge #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] gpio_raw,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0] sync_q [STAGES];
    logic [WIDTH-1:0] prev_q;

    // Synchroniser chain followed by one history flop for edge detection.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < STAGES; i++) begin
                sync_q[i] <= '0;
            end
            prev_q <= '0;
        end else begin
            sync_q[0] <= gpio_raw;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/rfsoc_gpio_cfg_bank.sv
// rfsoc_gpio_cfg_bank: GPIO-driven, double-buffered configuration register
// bank for the RFSoC PL.
//
// Ports:
//   clk, rstn    fabric clock, asynchronous active-low reset
//   gpio_in      raw PS GPIO bus (line map in rfsoc_config)
//   cfg_o        active registers, channel-major then register index
//   ch_sel_o     channel select shift register (one-hot or multi-hot)
//   trig_o       one-cycle trigger pulse
//   pl_rst_o     synchronised soft-reset level
//   commit_o     one-cycle pulse when the active registers update
//   cfg_err_o    sticky write-length error
//   rb_sdata_o   readback serial data
//
// Optional feature: define RFSOC_CFG_READBACK_EN to return the bit shifted
// out of the lowest selected channel on rb_sdata_o; otherwise it is tied 0.
module rfsoc_gpio_cfg_bank
    import rfsoc_config::*;
#(
    parameter int GPIO_W      = gpio_bus_width,
    parameter int NUM_CH      = 16,
    parameter int NUM_REGS    = NUM_CFG_REGS,
    parameter int REG_W       = config_reg_width,
    parameter int SYNC_STAGES = 2
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic [GPIO_W-1:0]                gpio_in,
    output logic [NUM_CH*NUM_REGS*REG_W-1:0] cfg_o,
    output logic [NUM_CH-1:0]                ch_sel_o,
    output logic                             trig_o,
    output logic                             pl_rst_o,
    output logic                             commit_o,
    output logic                             cfg_err_o,
    output logic                             rb_sdata_o
);

    localparam int CNT_W = $clog2(REG_W + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(REG_W);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(REG_W + 1);

    logic [GPIO_W-1:0] level;
    logic [GPIO_W-1:0] rise;

    rfsoc_gpio_sync_edge #(
        .WIDTH  (GPIO_W),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rstn     (rstn),
        .gpio_raw (gpio_in),
        .level    (level),
        .rise     (rise)
    );

    logic                sdata_bit;
    logic                soft_rst;
    logic                sel_edge;
    logic                commit_edge;
    logic                trig_edge;
    logic [NUM_REGS-1:0] reg_edge;

    assign sdata_bit   = level[sdata];
    assign soft_rst    = level[pl_rst];
    assign sel_edge    = rise[ch_sel_clk];
    assign commit_edge = rise[cfg_commit];
    assign trig_edge   = rise[trigger];

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg_edge
        assign reg_edge[r] = rise[CFG_CLK_IDX[r]];
    end

    // Spare GPIO lines and unused level/edge bits are collected here.
    logic unused_ok;
    assign unused_ok = ^{level, rise};

    logic [NUM_CH-1:0]                           sel;
    logic [NUM_CH-1:0][NUM_REGS-1:0][REG_W-1:0]  stage;
    logic [NUM_CH-1:0][NUM_REGS-1:0][REG_W-1:0]  active;
    logic [NUM_REGS-1:0][CNT_W-1:0]              cnt;
    logic                                        cfg_err;
    logic                                        commit_q;
    logic                                        trig_q;
    logic                                        trig_hold;
    logic                                        len_bad;

    // A register is complete only if it received exactly REG_W bits or none.
    always_comb begin
        len_bad = 1'b0;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (cnt[r] != '0 && cnt[r] != CNT_FULL) begin
                len_bad = 1'b1;
            end
        end
    end

    // Channel select shift register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sel <= '0;
        end else if (soft_rst) begin
            sel <= '0;
        end else if (sel_edge) begin
            sel <= {sel[NUM_CH-2:0], sdata_bit};
        end
    end

    // Staging shift registers and per-register bit counters. The shift uses
    // the pre-update select; a commit in the same cycle restarts the count
    // with the bit that arrives alongside it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stage <= '0;
            cnt   <= '0;
        end else if (soft_rst) begin
            stage <= '0;
            cnt   <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (reg_edge[r]) begin
                    for (int c = 0; c < NUM_CH; c++) begin
                        if (sel[c]) begin
                            stage[c][r] <= {stage[c][r][REG_W-2:0], sdata_bit};
                        end
                    end
                end
                if (commit_edge) begin
                    cnt[r] <= reg_edge[r] ? CNT_W'(1) : '0;
                end else if (reg_edge[r] && cnt[r] != CNT_SAT) begin
                    cnt[r] <= cnt[r] + CNT_W'(1);
                end
            end
        end
    end

    // Commit copies the pre-shift staging image and latches length errors.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            active   <= '0;
            commit_q <= 1'b0;
            cfg_err  <= 1'b0;
        end else if (soft_rst) begin
            active   <= '0;
            commit_q <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            commit_q <= commit_edge;
            if (commit_edge) begin
                active <= stage;
                if (len_bad) begin
                    cfg_err <= 1'b1;
                end
            end
        end
    end

    // A trigger arriving with a commit is held back one cycle so the
    // consumer always sees the freshly committed configuration.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            trig_q    <= 1'b0;
            trig_hold <= 1'b0;
        end else if (soft_rst) begin
            trig_q    <= 1'b0;
            trig_hold <= 1'b0;
        end else begin
            trig_q    <= (trig_edge & ~commit_edge) | trig_hold;
            trig_hold <= trig_edge & commit_edge;
        end
    end

`ifdef RFSOC_CFG_READBACK_EN
    logic rb_bit;
    logic rb_q;

    // Bit leaving the lowest selected channel of the lowest clocked register.
    always_comb begin
        rb_bit = 1'b0;
        for (int r = NUM_REGS - 1; r >= 0; r--) begin
            if (reg_edge[r]) begin
                rb_bit = 1'b0;
                for (int c = NUM_CH - 1; c >= 0; c--) begin
                    if (sel[c]) begin
                        rb_bit = stage[c][r][REG_W-1];
                    end
                end
            end
        end
    end

    // Readback holds its value between register clock edges.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rb_q <= 1'b0;
        end else if (!soft_rst && |reg_edge) begin
            rb_q <= rb_bit;
        end
    end

    assign rb_sdata_o = rb_q;
`else
    assign rb_sdata_o = 1'b0;
`endif

    assign cfg_o     = active;
    assign ch_sel_o  = sel;
    assign trig_o    = trig_q;
    assign pl_rst_o  = soft_rst;
    assign commit_o  = commit_q;
    assign cfg_err_o = cfg_err;

endmodule

// File: tb/tb_rfsoc_gpio_cfg_bank.sv
// tb_rfsoc_gpio_cfg_bank: self-checking bench for rfsoc_gpio_cfg_bank.
//
// Drives the GPIO bus as the PS would (every level held HOLD cycles) and
// keeps a register-level model of the bank: select word, staging and active
// arrays, bit counts, error flag and pulse counts. A monitor compares the
// DUT against the model once outputs have settled after each GPIO change.
// Build with RFSOC_CFG_READBACK_EN defined to also check readback.
module tb_rfsoc_gpio_cfg_bank;
    import rfsoc_config::*;

    localparam int GW   = 16;
    localparam int NC   = 16;
    localparam int NR   = 8;
    localparam int RW   = 32;
    localparam int SS   = 2;
    localparam int HOLD = 5;

    logic              clk     = 1'b0;
    logic              rstn    = 1'b0;
    logic [GW-1:0]     gpio_in = '0;
    logic [NC*NR*RW-1:0] cfg_o;
    logic [NC-1:0]     ch_sel_o;
    logic              trig_o;
    logic              pl_rst_o;
    logic              commit_o;
    logic              cfg_err_o;
    logic              rb_sdata_o;

    rfsoc_gpio_cfg_bank #(
        .GPIO_W      (GW),
        .NUM_CH      (NC),
        .NUM_REGS    (NR),
        .REG_W       (RW),
        .SYNC_STAGES (SS)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .gpio_in    (gpio_in),
        .cfg_o      (cfg_o),
        .ch_sel_o   (ch_sel_o),
        .trig_o     (trig_o),
        .pl_rst_o   (pl_rst_o),
        .commit_o   (commit_o),
        .cfg_err_o  (cfg_err_o),
        .rb_sdata_o (rb_sdata_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    logic [NC-1:0] m_sel;
    logic [RW-1:0] m_stage  [NC][NR];
    logic [RW-1:0] m_active [NC][NR];
    int            m_cnt    [NR];
    logic          m_err;
    logic          m_rb;
    int            m_commits;
    int            m_trigs;
    bit            m_trig_late;

    // Monitor state.
    int                  seen_commits = 0;
    int                  seen_trigs   = 0;
    int                  quiet        = 0;
    int                  commit_quiet = -1;
    int                  trig_quiet   = -1;
    logic [GW-1:0]       last_gpio    = '0;
    logic [NC*NR*RW-1:0] prev_cfg     = '0;
    logic [NC*NR*RW-1:0] cfg_at_trig  = '0;
    logic                prev_commit  = 1'b0;

    function automatic logic [GW-1:0] lineBit(input int line);
        return GW'(1) << line;
    endfunction

    function automatic logic [RW-1:0] field(input logic [NC*NR*RW-1:0] v, input int c, input int r);
        return v[(c*NR + r)*RW +: RW];
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic modelReset();
        m_sel = '0;
        for (int c = 0; c < NC; c++) begin
            for (int r = 0; r < NR; r++) begin
                m_stage[c][r]  = '0;
                m_active[c][r] = '0;
            end
        end
        for (int r = 0; r < NR; r++) m_cnt[r] = 0;
        m_err       = 1'b0;
        m_rb        = 1'b0;
        m_trig_late = 1'b0;
    endtask

    // Apply the effect of one GPIO transition to the model.
    task automatic modelStep(input logic [GW-1:0] old_v, input logic [GW-1:0] new_v);
        logic [GW-1:0] up;
        logic          d;
        int            rsel;
        up = new_v & ~old_v;
        d  = new_v[sdata];
        m_trig_late = 1'b0;
        if (new_v[pl_rst]) begin
            m_sel = '0;
            for (int c = 0; c < NC; c++) begin
                for (int r = 0; r < NR; r++) begin
                    m_stage[c][r]  = '0;
                    m_active[c][r] = '0;
                end
            end
            for (int r = 0; r < NR; r++) m_cnt[r] = 0;
            m_err = 1'b0;
            return;
        end
        if (up[cfg_commit]) begin
            for (int c = 0; c < NC; c++) begin
                for (int r = 0; r < NR; r++) m_active[c][r] = m_stage[c][r];
            end
            for (int r = 0; r < NR; r++) begin
                if (m_cnt[r] != 0 && m_cnt[r] != RW) m_err = 1'b1;
                m_cnt[r] = 0;
            end
            m_commits++;
        end
        if (up[trigger]) begin
            m_trigs++;
            m_trig_late = up[cfg_commit];
        end
        rsel = -1;
        for (int r = 0; r < NR; r++) begin
            if (up[CFG_CLK_IDX[r]] && rsel < 0) rsel = r;
        end
        if (rsel >= 0) begin
            m_rb = 1'b0;
            for (int c = 0; c < NC; c++) begin
                if (m_sel[c]) begin
                    m_rb = m_stage[c][rsel][RW-1];
                    break;
                end
            end
        end
        for (int r = 0; r < NR; r++) begin
            if (up[CFG_CLK_IDX[r]]) begin
                for (int c = 0; c < NC; c++) begin
                    if (m_sel[c]) m_stage[c][r] = {m_stage[c][r][RW-2:0], d};
                end
                if (m_cnt[r] < RW + 1) m_cnt[r]++;
            end
        end
        if (up[ch_sel_clk]) m_sel = {m_sel[NC-2:0], d};
    endtask

    task automatic applyStimulus(input logic [GW-1:0] v);
        modelStep(gpio_in, v);
        gpio_in = v;
        repeat (HOLD) @(negedge clk);
    endtask

    task automatic shiftBit(input int line, input logic b, input logic [GW-1:0] extra, input logic [GW-1:0] base);
        applyStimulus(base | GW'(b));
        applyStimulus(base | GW'(b) | lineBit(line) | extra);
    endtask

    task automatic writeReg(input int r, input logic [RW-1:0] val, input int nbits, input bit commit_last);
        for (int i = nbits - 1; i >= 0; i--) begin
            shiftBit(CFG_CLK_IDX[r], (i < RW) ? val[i % RW] : 1'b0,
                     (commit_last && i == 0) ? lineBit(cfg_commit) : '0, '0);
        end
        applyStimulus('0);
    endtask

    task automatic writeSel(input logic [NC-1:0] val, input int nbits);
        for (int i = nbits - 1; i >= 0; i--) shiftBit(ch_sel_clk, val[i], '0, '0);
        applyStimulus('0);
    endtask

    task automatic pulseLines(input logic [GW-1:0] v);
        applyStimulus(v);
        applyStimulus('0);
    endtask

    task automatic compareState();
        logic [NC*NR*RW-1:0] exp_cfg;
        int   bf;
        logic exp_rb;
        bf = 0;
        for (int c = 0; c < NC; c++) begin
            for (int r = 0; r < NR; r++) exp_cfg[(c*NR + r)*RW +: RW] = m_active[c][r];
        end
        for (int f = NC*NR - 1; f >= 0; f--) begin
            if (cfg_o[f*RW +: RW] !== exp_cfg[f*RW +: RW]) bf = f;
        end
        checkOutput($sformatf("cfg_o field %0d", bf), cfg_o[bf*RW +: RW], exp_cfg[bf*RW +: RW]);
        checkOutput("ch_sel_o", 32'(ch_sel_o), 32'(m_sel));
        checkOutput("cfg_err_o", 32'(cfg_err_o), 32'(m_err));
        checkOutput("pl_rst_o", 32'(pl_rst_o), 32'(gpio_in[pl_rst]));
`ifdef RFSOC_CFG_READBACK_EN
        exp_rb = m_rb;
`else
        exp_rb = 1'b0;
`endif
        checkOutput("rb_sdata_o", 32'(rb_sdata_o), 32'(exp_rb));
    endtask

    // Monitor: pulse latency/width, cfg_o stability, settled-state compare.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rstn) begin
                if (gpio_in !== last_gpio) begin
                    quiet     = 0;
                    last_gpio = gpio_in;
                end else if (quiet < 1000) begin
                    quiet++;
                end
                if (commit_o) begin
                    seen_commits++;
                    commit_quiet = quiet;
                    checkOutput("commit_o latency", 32'(quiet), 32'(SS + 1));
                    checkOutput("commit_o width", 32'(prev_commit), 32'd0);
                end
                if (trig_o) begin
                    seen_trigs++;
                    trig_quiet  = quiet;
                    cfg_at_trig = cfg_o;
                    checkOutput("trig_o latency", 32'(quiet), m_trig_late ? 32'(SS + 2) : 32'(SS + 1));
                end
                if (!pl_rst_o && cfg_o !== prev_cfg) begin
                    checkOutput("cfg_o change without commit_o", 32'(commit_o), 32'd1);
                end
                if (quiet == HOLD - 1) compareState();
            end
            prev_cfg    = cfg_o;
            prev_commit = commit_o;
        end
    end

    initial begin
        logic [NC*NR*RW-1:0] snap;
        logic [7:0]          rb_byte;
        int                  c0;
        int                  t0;
        int                  op;

        // Reset with a noisy bus: everything must read 0.
        modelReset();
        m_commits = 0;
        m_trigs   = 0;
        rstn = 1'b0;
        repeat (4) begin
            @(negedge clk);
            gpio_in = GW'($urandom);
        end
        @(negedge clk);
        checkOutput("reset cfg_o nonzero", 32'(cfg_o !== '0), 32'd0);
        checkOutput("reset ch_sel_o", 32'(ch_sel_o), 32'd0);
        checkOutput("reset outputs", {27'd0, trig_o, pl_rst_o, commit_o, cfg_err_o, rb_sdata_o}, 32'd0);
        gpio_in = '0;
        repeat (4) @(negedge clk);
        rstn = 1'b1;
        repeat (6) @(negedge clk);
        checkOutput("cfg_o after release", 32'(cfg_o !== '0), 32'd0);

        // Single write to channel 3 CYCLE_COUNT.
        c0 = seen_commits;
        writeSel(16'h0008, 16);
        checkOutput("sel one-hot", 32'(ch_sel_o), 32'h0008);
        writeReg(CYCLE_COUNT, 32'hDEADBEEF, RW, 1'b0);
        checkOutput("cfg_o before commit", 32'(cfg_o !== '0), 32'd0);
        pulseLines(lineBit(cfg_commit));
        checkOutput("ch3 CYCLE_COUNT", field(cfg_o, 3, CYCLE_COUNT), 32'hDEADBEEF);
        snap = cfg_o;
        snap[(3*NR + 1)*RW +: RW] = '0;
        checkOutput("other fields zero", 32'(snap !== '0), 32'd0);
        checkOutput("single commit pulse", 32'(seen_commits - c0), 32'd1);
        checkOutput("no length error", 32'(cfg_err_o), 32'd0);

        // Broadcast to ch0/ch2 and double-buffering across a trigger.
        writeSel(16'h0005, 16);
        writeReg(MASK, 32'h00001234, RW, 1'b0);
        snap = cfg_o;
        t0 = seen_trigs;
        pulseLines(lineBit(trigger));
        checkOutput("trigger pulse", 32'(seen_trigs - t0), 32'd1);
        checkOutput("cfg_o unchanged by trigger", 32'(cfg_o !== snap), 32'd0);
        pulseLines(lineBit(cfg_commit));
        checkOutput("ch0 MASK", field(cfg_o, 0, MASK), 32'h00001234);
        checkOutput("ch2 MASK", field(cfg_o, 2, MASK), 32'h00001234);
        checkOutput("ch1 MASK", field(cfg_o, 1, MASK), 32'h0);
        checkOutput("ch3 CYCLE_COUNT kept", field(cfg_o, 3, CYCLE_COUNT), 32'hDEADBEEF);

        // Short write is flagged, stays flagged, soft reset clears it.
        writeReg(PRE_DELAY, 32'h7FFFFFFF, RW - 1, 1'b0);
        pulseLines(lineBit(cfg_commit));
        checkOutput("length error set", 32'(cfg_err_o), 32'd1);
        pulseLines(lineBit(cfg_commit));
        checkOutput("length error sticky", 32'(cfg_err_o), 32'd1);
        pulseLines(lineBit(pl_rst));
        checkOutput("length error cleared", 32'(cfg_err_o), 32'd0);
        checkOutput("soft reset clears cfg_o", 32'(cfg_o !== '0), 32'd0);

        // Commit and trigger in the same synchronised cycle.
        writeSel(16'h0001, 16);
        writeReg(ADC_SHIFT, 32'hCAFEF00D, RW, 1'b0);
        pulseLines(lineBit(cfg_commit) | lineBit(trigger));
        checkOutput("simultaneous commit at N", 32'(commit_quiet), 32'd3);
        checkOutput("simultaneous trigger at N+1", 32'(trig_quiet), 32'd4);
        checkOutput("cfg_o new at trigger", field(cfg_at_trig, 0, ADC_SHIFT), 32'hCAFEF00D);

`ifdef RFSOC_CFG_READBACK_EN
        // Readback returns the previously staged word, MSB first.
        writeSel(16'h0002, 16);
        writeReg(LOCK_WAVE, 32'hA5A5A5A5, RW, 1'b0);
        rb_byte = '0;
        for (int i = 0; i < RW; i++) begin
            shiftBit(CFG_CLK_IDX[LOCK_WAVE], 1'($urandom_range(0, 1)), '0, '0);
            if (i < 8) rb_byte = {rb_byte[6:0], rb_sdata_o};
        end
        applyStimulus('0);
        checkOutput("readback first byte", 32'(rb_byte), 32'h000000A5);
        pulseLines(lineBit(cfg_commit));
`endif

        // Randomised traffic checked by the monitor against the model.
        for (int n = 0; n < 40; n++) begin
            op = $urandom_range(0, 7);
            case (op)
                0: writeSel(($urandom_range(0, 3) == 0) ? '0 : NC'($urandom), $urandom_range(1, NC));
                1, 2: writeReg($urandom_range(0, NR - 1), $urandom,
                               ($urandom_range(0, 2) == 0) ? $urandom_range(0, RW + 2) : RW, 1'b0);
                3: writeReg($urandom_range(0, NR - 1), $urandom, $urandom_range(1, RW), 1'b1);
                4: pulseLines(lineBit(cfg_commit));
                5: pulseLines(lineBit(trigger));
                6: pulseLines(lineBit(cfg_commit) | lineBit(trigger));
                default: begin
                    applyStimulus(lineBit(pl_rst));
                    shiftBit(CFG_CLK_IDX[$urandom_range(0, NR - 1)], 1'b1, '0, lineBit(pl_rst));
                    shiftBit(ch_sel_clk, 1'b1, '0, lineBit(pl_rst));
                    applyStimulus(lineBit(pl_rst) | lineBit(cfg_commit));
                    applyStimulus(lineBit(pl_rst) | lineBit(trigger));
                    applyStimulus('0);
                end
            endcase
        end
        applyStimulus('0);

        checkOutput("commit pulse count", 32'(seen_commits), 32'(m_commits));
        checkOutput("trigger pulse count", 32'(seen_trigs), 32'(m_trigs));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
